cxu_cmd_pipe: RTL and testbench
===============================

Name: cxu_cmd_pipe

Overview:
Registered pipelining shim between the CPU-side CXU port and a combinational CXU such as the Q10 fixed-point multiply unit.
- Buffers commands in a small FIFO toward the CXU.
- Registers responses back to the CPU through a 2-entry skid buffer.
- Limits in-flight commands with an outstanding counter.
- Breaks the combinational cmd_ready/rsp_ready loop a pass-through CXU creates.

Parameters:
CMD_DEPTH, 2, command FIFO entries; power of 2, >=2
MAX_OUTSTANDING, 4, max commands accepted upstream but not yet returned upstream; >=1

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
s_cmd_valid  in  1  CPU command valid
s_cmd_ready  out  1  command accepted
s_cmd_payload_function_id  in  3  function select
s_cmd_payload_inputs_0  in  32  operand 0
s_cmd_payload_inputs_1  in  32  operand 1
s_cmd_payload_state_id  in  3  state select
s_cmd_payload_cxu_id  in  4  CXU select
s_cmd_payload_ready  in  1  payload ready flag
s_rsp_valid  out  1  response to CPU valid
s_rsp_ready  in  1  CPU accepts response
s_rsp_payload_outputs_0  out  32  result
s_rsp_payload_ready  out  1  response ready flag
m_cmd_valid, m_cmd_ready, m_cmd_payload_*  out/in  same widths as s_cmd_*  command to CXU
m_rsp_valid  in  1  CXU response valid
m_rsp_ready  out  1  shim accepts response
m_rsp_payload_outputs_0  in  32  CXU result
m_rsp_payload_ready  in  1  CXU response flag

Behaviour:
- Handshake: a transfer fires when valid && ready on the same rising edge. Valid must not depend on ready.
- Command FIFO:
  - Entry width 75 bits: fid3, in0 32, in1 32, sid3, cxu4, rdy1.
  - s_cmd_ready = !reset && !cmd_full && (outstanding < MAX_OUTSTANDING).
  - Full FIFO blocks a push even if a pop fires the same cycle; there is no pass-through.
  - Push to an empty FIFO: m_cmd_valid rises the next cycle. Minimum latency is 1 cycle.
  - m_cmd_payload_* come from a head register; they are 0 when empty.
  - Read and write pointers wrap modulo CMD_DEPTH. Order is preserved.
- Response skid buffer:
  - 2 entries.
  - m_rsp_ready = !rsp_full, taken from a register; it never depends combinationally on s_rsp_ready.
  - An accepted response appears on s_rsp_valid the next cycle.
  - Simultaneous push and pop with 1 entry: count stays 1 and data advances.
- Outstanding counter:
  - +1 on s_cmd fire, -1 on s_rsp fire, unchanged when both fire.
  - Range 0..MAX_OUTSTANDING; never wraps.
- Sticky error:
  - Internal err_unexpected_rsp sets when m_rsp fires while outstanding == 0.
  - It is cleared only by reset.
  - The response is still buffered.
- Reset values, for reset asserted at any time including mid-operation:
  - All FIFO and skid contents are discarded; pointers and counters go to 0.
  - s_rsp_valid = 0, m_cmd_valid = 0, all payload outputs = 0.
  - s_cmd_ready = 0 while reset is high; m_rsp_ready = 1 from the first cycle after reset.
- Round trip with a combinational CXU: command accept to s_rsp_valid = 2 cycles minimum.
- Throughput: 1 command per cycle sustained when downstream is ready.

Optional Feature:
CXU_PIPE_STATS_EN
- Defined:
  - Adds outputs perf_cmd_count (32) and perf_stall_count (32).
  - perf_cmd_count increments on each s_cmd fire.
  - perf_stall_count increments each cycle s_cmd_valid && !s_cmd_ready.
  - Both saturate at 0xFFFFFFFF and are reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
All tests run with the Q10 multiply CXU attached downstream.
- Single command, fid=0, in0=0x00000800, in1=0x00000C00 -> s_rsp_payload_outputs_0 = 0x00001800 exactly 2 cycles after accept.
- Same operands with fid=1 -> 0x00600000. Back-to-back 8 commands with s_rsp_ready=1 -> 8 in-order responses, 1 per cycle after fill.
- s_rsp_ready=0, push commands -> s_cmd_ready drops after 4 accepted (MAX_OUTSTANDING). Release s_rsp_ready -> 4 responses in order, then ready returns.
- Hold m_cmd_ready=0 -> FIFO fills at 2 entries, s_cmd_ready=0. Same-cycle push/pop attempt at full -> push not taken.
- Assert reset with 2 commands queued and 1 response held -> next cycle all valids 0, outputs 0, outstanding 0; no stale response after release.
- With CXU_PIPE_STATS_EN: 5 accepts and 3 stalled cycles -> perf_cmd_count=5, perf_stall_count=3. Preload near 0xFFFFFFFF -> counter holds at saturation.

Source files
------------

// File: rtl/cxu_cmd_pipe.sv
// cxu_cmd_pipe: command FIFO plus registered response skid buffer in front of a combinational CXU.
// Optional perf counters are enabled by defining CXU_PIPE_STATS_EN.
module cxu_cmd_pipe #(
  parameter int CMD_DEPTH       = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_cmd_valid,
  output logic        s_cmd_ready,
  input  logic [2:0]  s_cmd_payload_function_id,
  input  logic [31:0] s_cmd_payload_inputs_0,
  input  logic [31:0] s_cmd_payload_inputs_1,
  input  logic [2:0]  s_cmd_payload_state_id,
  input  logic [3:0]  s_cmd_payload_cxu_id,
  input  logic        s_cmd_payload_ready,
  output logic        s_rsp_valid,
  input  logic        s_rsp_ready,
  output logic [31:0] s_rsp_payload_outputs_0,
  output logic        s_rsp_payload_ready,
  output logic        m_cmd_valid,
  input  logic        m_cmd_ready,
  output logic [2:0]  m_cmd_payload_function_id,
  output logic [31:0] m_cmd_payload_inputs_0,
  output logic [31:0] m_cmd_payload_inputs_1,
  output logic [2:0]  m_cmd_payload_state_id,
  output logic [3:0]  m_cmd_payload_cxu_id,
  output logic        m_cmd_payload_ready,
  input  logic        m_rsp_valid,
  output logic        m_rsp_ready,
  input  logic [31:0] m_rsp_payload_outputs_0,
  input  logic        m_rsp_payload_ready
`ifdef CXU_PIPE_STATS_EN
  ,
  output logic [31:0] perf_cmd_count,
  output logic [31:0] perf_stall_count
`endif
);
  localparam int AW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  logic [74:0]   cmd_mem_q [CMD_DEPTH];
  logic [AW-1:0] cmd_wptr_q, cmd_rptr_q;
  logic [AW:0]   cmd_cnt_q, cmd_cnt_d;
  logic [OW-1:0] out_q, out_d;
  logic [32:0]   rsp_mem_q [2];
  logic          rsp_wptr_q, rsp_rptr_q, rsp_rdy_q, rsp_rdy_d, err_unexpected_rsp_q;
  logic [1:0]    rsp_cnt_q, rsp_cnt_d;
  logic          cmd_push, cmd_pop, rsp_push, rsp_pop;
  logic [74:0]   cmd_head;
  logic [32:0]   rsp_head;
  assign s_cmd_ready = !reset && (cmd_cnt_q != (AW+1)'(CMD_DEPTH)) && (out_q < OW'(MAX_OUTSTANDING));
  assign cmd_push    = s_cmd_valid && s_cmd_ready;
  assign m_cmd_valid = cmd_cnt_q != '0;
  assign cmd_pop     = m_cmd_valid && m_cmd_ready;
  assign cmd_head    = m_cmd_valid ? cmd_mem_q[cmd_rptr_q] : '0;
  assign {m_cmd_payload_function_id, m_cmd_payload_inputs_0, m_cmd_payload_inputs_1,
          m_cmd_payload_state_id, m_cmd_payload_cxu_id, m_cmd_payload_ready} = cmd_head;
  // m_rsp_ready is a flop so the CXU never sees a path from s_rsp_ready
  assign m_rsp_ready = rsp_rdy_q;
  assign rsp_push    = m_rsp_valid && rsp_rdy_q;
  assign s_rsp_valid = rsp_cnt_q != '0;
  assign rsp_pop     = s_rsp_valid && s_rsp_ready;
  assign rsp_head    = s_rsp_valid ? rsp_mem_q[rsp_rptr_q] : '0;
  assign {s_rsp_payload_outputs_0, s_rsp_payload_ready} = rsp_head;
  always_comb begin
    cmd_cnt_d = cmd_cnt_q + (AW+1)'(cmd_push) - (AW+1)'(cmd_pop);
    rsp_cnt_d = rsp_cnt_q + 2'(rsp_push) - 2'(rsp_pop);
    rsp_rdy_d = rsp_cnt_d != 2'd2;
    out_d     = (cmd_push && !rsp_pop) ? out_q + OW'(1) :
                (rsp_pop && !cmd_push && out_q != '0) ? out_q - OW'(1) : out_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_wptr_q           <= '0;
      cmd_rptr_q           <= '0;
      cmd_cnt_q            <= '0;
      rsp_wptr_q           <= 1'b0;
      rsp_rptr_q           <= 1'b0;
      rsp_cnt_q            <= '0;
      rsp_rdy_q            <= 1'b1;
      out_q                <= '0;
      err_unexpected_rsp_q <= 1'b0;
    end else begin
      cmd_cnt_q            <= cmd_cnt_d;
      rsp_cnt_q            <= rsp_cnt_d;
      rsp_rdy_q            <= rsp_rdy_d;
      out_q                <= out_d;
      cmd_wptr_q           <= cmd_push ? cmd_wptr_q + AW'(1) : cmd_wptr_q;
      cmd_rptr_q           <= cmd_pop ? cmd_rptr_q + AW'(1) : cmd_rptr_q;
      rsp_wptr_q           <= rsp_push ? !rsp_wptr_q : rsp_wptr_q;
      rsp_rptr_q           <= rsp_pop ? !rsp_rptr_q : rsp_rptr_q;
      err_unexpected_rsp_q <= err_unexpected_rsp_q || (rsp_push && out_q == '0);
    end
  end
  // storage needs no reset: the counts gate every read
  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem_q[cmd_wptr_q] <= {s_cmd_payload_function_id, s_cmd_payload_inputs_0,
      s_cmd_payload_inputs_1, s_cmd_payload_state_id, s_cmd_payload_cxu_id, s_cmd_payload_ready};
    if (rsp_push) rsp_mem_q[rsp_wptr_q] <= {m_rsp_payload_outputs_0, m_rsp_payload_ready};
  end
`ifdef CXU_PIPE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cmd_count   <= '0;
      perf_stall_count <= '0;
    end else begin
      perf_cmd_count   <= perf_cmd_count + 32'(cmd_push && !(&perf_cmd_count));
      perf_stall_count <= perf_stall_count + 32'(s_cmd_valid && !s_cmd_ready && !(&perf_stall_count));
    end
  end
`endif
endmodule

// File: tb/tb_cxu_cmd_pipe.sv
// tb_cxu_cmd_pipe: directed bench for cxu_cmd_pipe with a Q10 multiply CXU stand-in downstream.
module tb_cxu_cmd_pipe;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  logic        s_cmd_valid = 1'b0, s_cmd_ready, s_cmd_payload_ready = 1'b0;
  logic [2:0]  s_cmd_payload_function_id = '0, s_cmd_payload_state_id = '0;
  logic [31:0] s_cmd_payload_inputs_0 = '0, s_cmd_payload_inputs_1 = '0;
  logic [3:0]  s_cmd_payload_cxu_id = '0;
  logic        s_rsp_valid, s_rsp_ready = 1'b1, s_rsp_payload_ready;
  logic [31:0] s_rsp_payload_outputs_0;
  logic        m_cmd_valid, m_cmd_ready, m_cmd_payload_ready;
  logic [2:0]  m_cmd_payload_function_id, m_cmd_payload_state_id;
  logic [31:0] m_cmd_payload_inputs_0, m_cmd_payload_inputs_1;
  logic [3:0]  m_cmd_payload_cxu_id;
  logic        m_rsp_valid, m_rsp_ready, m_rsp_payload_ready;
  logic [31:0] m_rsp_payload_outputs_0;
`ifdef CXU_PIPE_STATS_EN
  logic [31:0] perf_cmd_count, perf_stall_count;
`endif
  logic cxu_en = 1'b1;
  logic signed [63:0] pa, pb, prod;
  // Q10 multiply: fid 0 is the fixed-point product, fid 1 the raw low word
  assign pa = {{32{m_cmd_payload_inputs_0[31]}}, m_cmd_payload_inputs_0};
  assign pb = {{32{m_cmd_payload_inputs_1[31]}}, m_cmd_payload_inputs_1};
  assign prod = pa * pb;
  assign m_rsp_payload_outputs_0 = (m_cmd_payload_function_id == 3'd1) ? prod[31:0] : prod[41:10];
  assign m_rsp_payload_ready = m_cmd_payload_ready;
  assign m_rsp_valid = m_cmd_valid && cxu_en;
  assign m_cmd_ready = m_rsp_ready && cxu_en;

  cxu_cmd_pipe dut (
    .clk(clk), .reset(reset),
    .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
    .s_cmd_payload_function_id(s_cmd_payload_function_id),
    .s_cmd_payload_inputs_0(s_cmd_payload_inputs_0), .s_cmd_payload_inputs_1(s_cmd_payload_inputs_1),
    .s_cmd_payload_state_id(s_cmd_payload_state_id), .s_cmd_payload_cxu_id(s_cmd_payload_cxu_id),
    .s_cmd_payload_ready(s_cmd_payload_ready),
    .s_rsp_valid(s_rsp_valid), .s_rsp_ready(s_rsp_ready),
    .s_rsp_payload_outputs_0(s_rsp_payload_outputs_0), .s_rsp_payload_ready(s_rsp_payload_ready),
    .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
    .m_cmd_payload_function_id(m_cmd_payload_function_id),
    .m_cmd_payload_inputs_0(m_cmd_payload_inputs_0), .m_cmd_payload_inputs_1(m_cmd_payload_inputs_1),
    .m_cmd_payload_state_id(m_cmd_payload_state_id), .m_cmd_payload_cxu_id(m_cmd_payload_cxu_id),
    .m_cmd_payload_ready(m_cmd_payload_ready),
    .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready),
    .m_rsp_payload_outputs_0(m_rsp_payload_outputs_0), .m_rsp_payload_ready(m_rsp_payload_ready)
`ifdef CXU_PIPE_STATS_EN
    , .perf_cmd_count(perf_cmd_count), .perf_stall_count(perf_stall_count)
`endif
  );

  typedef struct {
    logic [2:0]  fid;
    logic [31:0] a;
    logic [31:0] b;
    logic        rdy;
    logic [31:0] exp;
  } vec_t;
  vec_t vec [8];
  int n_tests = 0, n_fail = 0, cyc = 0, first_cyc = 0, last_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int i);
    s_cmd_payload_function_id = vec[i % 8].fid;
    s_cmd_payload_inputs_0    = vec[i % 8].a;
    s_cmd_payload_inputs_1    = vec[i % 8].b;
    s_cmd_payload_ready       = vec[i % 8].rdy;
    s_cmd_payload_state_id    = 3'(i);
    s_cmd_payload_cxu_id      = 4'(i);
  endtask

  task automatic send(input int i);
    int w = 0;
    drive(i);
    s_cmd_valid = 1'b1;
    while (!s_cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w == 50) chk("send_timeout", 64'(w), 64'(0));
    @(negedge clk);
    s_cmd_valid = 1'b0;
  endtask

  task automatic push_for(input int ncyc, output int acc);
    acc = 0;
    for (int k = 0; k < ncyc; k++) begin
      drive(acc);
      s_cmd_valid = 1'b1;
      if (s_cmd_ready) acc++;
      @(negedge clk);
    end
    s_cmd_valid = 1'b0;
  endtask

  task automatic collect(input int n, input int base, input int budget);
    int got = 0, c = 0;
    while (got < n && c < budget) begin
      if (s_rsp_valid && s_rsp_ready) begin
        if (got == 0) first_cyc = cyc;
        last_cyc = cyc;
        chk("rsp_order", {s_rsp_payload_outputs_0, s_rsp_payload_ready},
            {vec[(base + got) % 8].exp, vec[(base + got) % 8].rdy});
        got++;
      end
      @(negedge clk);
      c++;
    end
    chk("rsp_count", 64'(got), 64'(n));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    s_cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int acc, stray;
    vec[0] = '{3'd0, 32'h0000_0800, 32'h0000_0C00, 1'b1, 32'h0000_1800};
    vec[1] = '{3'd1, 32'h0000_0800, 32'h0000_0C00, 1'b0, 32'h0060_0000};
    vec[2] = '{3'd0, 32'hFFFF_FC00, 32'h0000_0800, 1'b1, 32'hFFFF_F800};
    vec[3] = '{3'd0, 32'h0000_0200, 32'h0000_0200, 1'b0, 32'h0000_0100};
    vec[4] = '{3'd1, 32'h0001_0000, 32'h0001_0000, 1'b1, 32'h0000_0000};
    vec[5] = '{3'd1, 32'h1234_5678, 32'h0000_0001, 1'b0, 32'h1234_5678};
    vec[6] = '{3'd0, 32'h0000_0007, 32'h0000_0003, 1'b1, 32'h0000_0000};
    vec[7] = '{3'd0, 32'h0010_0000, 32'h0000_0400, 1'b0, 32'h0010_0000};
    repeat (2) @(negedge clk);
    chk("reset_cmd_ready", 64'(s_cmd_ready), 64'(0));
    chk("reset_valids", {m_cmd_valid, s_rsp_valid}, 64'(0));
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_m_rsp_ready", 64'(m_rsp_ready), 64'(1));
    chk("post_reset_cmd_ready", 64'(s_cmd_ready), 64'(1));
    chk("post_reset_rsp_payload", {s_rsp_payload_outputs_0, s_rsp_payload_ready}, 64'(0));
    chk("post_reset_cmd_payload", {m_cmd_payload_inputs_0, m_cmd_payload_inputs_1}, 64'(0));
    // single commands: accept, one cycle in the FIFO, response registered the next
    for (int i = 0; i < 8; i++) begin
      drive(i);
      s_cmd_valid = 1'b1;
      chk("single_cmd_ready", 64'(s_cmd_ready), 64'(1));
      @(negedge clk);
      s_cmd_valid = 1'b0;
      chk("single_lat1_idle", 64'(s_rsp_valid), 64'(0));
      @(negedge clk);
      chk("single_lat2_valid", 64'(s_rsp_valid), 64'(1));
      chk("single_rsp", {s_rsp_payload_outputs_0, s_rsp_payload_ready}, {vec[i].exp, vec[i].rdy});
      @(negedge clk);
      chk("single_drained", 64'(s_rsp_valid), 64'(0));
    end
    // back-to-back 8 commands at full rate
    fork
      begin
        for (int i = 0; i < 8; i++) send(i);
      end
      collect(8, 0, 60);
    join
    chk("b2b_span", 64'(last_cyc - first_cyc), 64'(7));
    // outstanding limit with the CPU stalling responses
    s_rsp_ready = 1'b0;
    push_for(8, acc);
    chk("outstanding_accepts", 64'(acc), 64'(4));
    chk("outstanding_cmd_ready", 64'(s_cmd_ready), 64'(0));
    chk("outstanding_m_rsp_ready", 64'(m_rsp_ready), 64'(0));
    s_rsp_ready = 1'b1;
    collect(4, 0, 30);
    chk("outstanding_ready_back", 64'(s_cmd_ready), 64'(1));
    // full FIFO, then a push attempted in the same cycle as a pop
    cxu_en = 1'b0;
    push_for(4, acc);
    chk("full_accepts", 64'(acc), 64'(2));
    chk("full_cmd_ready", 64'(s_cmd_ready), 64'(0));
    chk("full_head", 64'(m_cmd_payload_inputs_0), 64'(vec[0].a));
    cxu_en = 1'b1;
    drive(2);
    s_cmd_valid = 1'b1;
    @(negedge clk);
    s_cmd_valid = 1'b0;
    collect(2, 0, 20);
    stray = 0;
    repeat (4) begin
      if (s_rsp_valid) stray++;
      @(negedge clk);
    end
    chk("full_push_not_taken", 64'(stray), 64'(0));
    // reset with 2 commands queued and 1 response held
    s_rsp_ready = 1'b0;
    send(0);
    @(negedge clk);
    cxu_en = 1'b0;
    send(1);
    send(2);
    chk("pre_reset_state", {s_rsp_valid, m_cmd_valid, s_cmd_ready}, 64'b110);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_valids", {s_rsp_valid, m_cmd_valid, s_cmd_ready}, 64'(0));
    chk("midrst_rsp_payload", {s_rsp_payload_outputs_0, s_rsp_payload_ready}, 64'(0));
    chk("midrst_cmd_payload", {m_cmd_payload_inputs_0, m_cmd_payload_inputs_1}, 64'(0));
    chk("midrst_cmd_fields", {m_cmd_payload_function_id, m_cmd_payload_state_id,
                              m_cmd_payload_cxu_id, m_cmd_payload_ready}, 64'(0));
    reset = 1'b0;
    cxu_en = 1'b1;
    s_rsp_ready = 1'b1;
    @(negedge clk);
    chk("postrst_m_rsp_ready", 64'(m_rsp_ready), 64'(1));
    stray = 0;
    repeat (5) begin
      if (s_rsp_valid) stray++;
      @(negedge clk);
    end
    chk("postrst_no_stale", 64'(stray), 64'(0));
    fork
      send(3);
      collect(1, 3, 10);
    join
`ifdef CXU_PIPE_STATS_EN
    do_reset();
    cxu_en = 1'b0;
    push_for(5, acc);
    cxu_en = 1'b1;
    collect(2, 0, 20);
    fork
      begin
        send(2);
        send(3);
        send(4);
      end
      collect(3, 2, 40);
    join
    chk("perf_cmd_count", 64'(perf_cmd_count), 64'(5));
    chk("perf_stall_count", 64'(perf_stall_count), 64'(3));
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
